// File: rtl/uart_stream_display_buffer.sv
// Capture/replay buffer between a UART receiver and a two-digit hex display.
// Optional LOOP_PLAYBACK_EN: playback repeats endlessly and i_Play toggles it on/off.
module uart_stream_display_buffer #(
  parameter int DEPTH      = 16,
  parameter int DWELL_CLKS = 25000000
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_RX_DV,
  input  logic [7:0]               i_RX_Byte,
  input  logic                     i_Play,
  input  logic                     i_Clear,
  output logic [7:0]               o_Byte,
  output logic                     o_Playing,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Full,
  output logic                     o_Overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int DW = $clog2(DWELL_CLKS);

  // All inputs are single-cycle strobes with no back-pressure; a strobe that
  // cannot be honoured is dropped. Priority: i_Clear > i_Play > i_RX_DV.
  typedef enum logic {S_IDLE, S_PLAY} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   dwell_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      byte_q;
  logic            play_q;
  logic            full_q;
  logic            ovf_q;
  logic [7:0]      mem_q [DEPTH];

  logic [IW-1:0]   last_idx_d;
  logic [IW-1:0]   idx_inc_d;
  logic [CW-1:0]   count_inc_d;
  logic            dwell_end_d;
  logic            wr_en_d;

  always_comb begin
    last_idx_d  = IW'(count_q - CW'(1));
    idx_inc_d   = idx_q + IW'(1);
    count_inc_d = count_q + CW'(1);
    dwell_end_d = (dwell_q == DW'(DWELL_CLKS - 1));
    wr_en_d     = i_RX_DV && !i_Clear && !i_Play && (state_q == S_IDLE) && !full_q;
  end

  // Storage has no reset; stale contents are never visible because count gates reads.
  always_ff @(posedge i_Clk) begin
    if (wr_en_d) mem_q[count_q[IW-1:0]] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      count_q <= '0;
      byte_q  <= '0;
      play_q  <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (i_Clear) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      count_q <= '0;
      byte_q  <= '0;
      play_q  <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (i_Play) begin
      if (state_q == S_IDLE) begin
        if (count_q != '0) begin
          state_q <= S_PLAY;
          idx_q   <= '0;
          dwell_q <= '0;
          byte_q  <= mem_q[0];
          play_q  <= 1'b1;
        end
      end else begin
`ifdef LOOP_PLAYBACK_EN
        state_q <= S_IDLE;
        play_q  <= 1'b0;
        byte_q  <= mem_q[last_idx_d];
`else
        idx_q   <= '0;
        dwell_q <= '0;
        byte_q  <= mem_q[0];
`endif
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_RX_DV) begin
            if (full_q) begin
              ovf_q <= 1'b1;
            end else begin
              count_q <= count_inc_d;
              full_q  <= (count_inc_d == CW'(DEPTH));
              byte_q  <= i_RX_Byte;
            end
          end
        end
        S_PLAY: begin
          if (i_RX_DV) ovf_q <= 1'b1;
          if (dwell_end_d) begin
            dwell_q <= '0;
            if (idx_q == last_idx_d) begin
`ifdef LOOP_PLAYBACK_EN
              idx_q   <= '0;
              byte_q  <= mem_q[0];
`else
              state_q <= S_IDLE;
              play_q  <= 1'b0;
              byte_q  <= mem_q[last_idx_d];
`endif
            end else begin
              idx_q  <= idx_inc_d;
              byte_q <= mem_q[idx_inc_d];
            end
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Byte     = byte_q;
  assign o_Playing  = play_q;
  assign o_Count    = count_q;
  assign o_Full     = full_q;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_stream_display_buffer.sv
// Bench for uart_stream_display_buffer (DEPTH=4, DWELL_CLKS=4): directed and random
// stimulus scored against a queue/arithmetic model of the capture/replay behaviour.
module tb_uart_stream_display_buffer;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int CW    = 3;
  localparam int W     = 8 + 1 + CW + 1 + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          play = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    o_byte;
  logic          o_playing;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_ovf;

  always #5 clk = ~clk;

  uart_stream_display_buffer #(.DEPTH(DEPTH), .DWELL_CLKS(DWELL)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_RX_DV    (rx_dv),
    .i_RX_Byte  (rx_byte),
    .i_Play     (play),
    .i_Clear    (clr),
    .o_Byte     (o_byte),
    .o_Playing  (o_playing),
    .o_Count    (o_count),
    .o_Full     (o_full),
    .o_Overflow (o_ovf)
  );

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           errors = 0;
  int           checks = 0;

  // Reference model: the buffer is a queue; playback position is elapsed cycles.
  logic [7:0] mbuf[$];
  int         m_t = 0;
  bit         m_play = 1'b0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;

  function automatic logic [W-1:0] model_pack();
    return {m_byte, m_play, CW'(mbuf.size()), 1'(mbuf.size() == DEPTH), m_ovf};
  endfunction

  function automatic logic [W-1:0] dut_pack();
    return {o_byte, o_playing, o_count, o_full, o_ovf};
  endfunction

  task automatic model_reset();
    mbuf.delete();
    m_t = 0;
    m_play = 1'b0;
    m_byte = 8'h00;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit p, input bit d, input logic [7:0] b);
    int n;
    n = mbuf.size();
    if (c) begin
      model_reset();
    end else if (p) begin
      if (m_play) begin
`ifdef LOOP_PLAYBACK_EN
        m_play = 1'b0;
        m_byte = mbuf[n-1];
`else
        m_t = 0;
        m_byte = mbuf[0];
`endif
      end else if (n > 0) begin
        m_play = 1'b1;
        m_t = 0;
        m_byte = mbuf[0];
      end
    end else if (m_play) begin
      if (d) m_ovf = 1'b1;
      m_t++;
      if (m_t >= n * DWELL) begin
`ifdef LOOP_PLAYBACK_EN
        m_t = m_t % (n * DWELL);
        m_byte = mbuf[m_t / DWELL];
`else
        m_play = 1'b0;
        m_byte = mbuf[n-1];
`endif
      end else begin
        m_byte = mbuf[m_t / DWELL];
      end
    end else if (d) begin
      if (n == DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        mbuf.push_back(b);
        m_byte = b;
      end
    end
  endtask

  task automatic cycle(input bit c, input bit p, input bit d, input logic [7:0] b, input string tag);
    @(negedge clk);
    clr = c;
    play = p;
    rx_dv = d;
    rx_byte = b;
    model_step(c, p, d, b);
    exp_q.push_back(model_pack());
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, tag);
  endtask

  task automatic check_zero(input string tag);
    logic [W-1:0] act;
    act = dut_pack();
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: got byte=%02h play=%0b count=%0d full=%0b ovf=%0b, want all zero",
               tag, o_byte, o_playing, o_count, o_full, o_ovf);
    end
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    clr = 1'b0;
    play = 1'b0;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    model_reset();
    #1;
    check_zero(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: outputs of each clocked cycle are compared just after the edge.
  initial begin
    logic [W-1:0] exp;
    logic [W-1:0] act;
    string        tag;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = dut_pack();
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s: got byte=%02h play=%0b count=%0d full=%0b ovf=%0b, want byte=%02h play=%0b count=%0d full=%0b ovf=%0b",
                   tag, act[W-1 -: 8], act[W-9], act[CW+1:2], act[1], act[0],
                   exp[W-1 -: 8], exp[W-9], exp[CW+1:2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit c, p, d;
    int r;

    #1;
    check_zero("reset_hold");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2, "reset_idle");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, "play_empty");
    idle(2, "play_empty_idle");

    cycle(1'b0, 1'b0, 1'b1, 8'h3A, "rx_3a");
    cycle(1'b0, 1'b0, 1'b1, 8'hC5, "rx_c5");
    idle(1, "rx_hold");

    cycle(1'b0, 1'b1, 1'b0, 8'h00, "play_start");
    idle(2, "play_e0");
    cycle(1'b0, 1'b0, 1'b1, 8'h77, "rx_in_play");
    idle(8, "play_run");

    cycle(1'b1, 1'b0, 1'b0, 8'h00, "clear");
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i), "fill");
    cycle(1'b0, 1'b0, 1'b1, 8'h05, "rx_full_drop");
    idle(1, "full_hold");
    cycle(1'b1, 1'b0, 1'b1, 8'h06, "clear_with_rx");
    idle(1, "clear_hold");

    cycle(1'b0, 1'b0, 1'b1, 8'h11, "rx_11");
    cycle(1'b0, 1'b0, 1'b1, 8'h22, "rx_22");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, "play_for_reset");
    idle(5, "play_to_e1c2");
    @(posedge clk);
    #3;
    async_reset("async_reset");
    idle(2, "post_reset_idle");

`ifdef LOOP_PLAYBACK_EN
    cycle(1'b0, 1'b0, 1'b1, 8'hAA, "loop_rx_aa");
    cycle(1'b0, 1'b0, 1'b1, 8'h55, "loop_rx_55");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, "loop_play");
    idle(18, "loop_run");
    cycle(1'b0, 1'b1, 1'b0, 8'h00, "loop_stop");
    idle(2, "loop_stopped");
    cycle(1'b1, 1'b0, 1'b0, 8'h00, "loop_clear");
`endif

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      c = (r < 2);
      p = (r >= 2 && r < 6);
      d = (r >= 6 && r < 40) || (c && ($urandom_range(0, 1) == 1));
      cycle(c, p, d, 8'($urandom_range(0, 255)), "random");
    end
    idle(1, "random_tail");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_stream_display_buffer.md
Name: uart_stream_display_buffer

Overview:
Capture/replay buffer between the UART receiver and the two-digit hex seven-segment driver. It stores each received byte in a small on-chip buffer and drives the 8-bit value shown on the display. In IDLE the display shows the most recently received byte. A play request steps through every stored byte in arrival order, holding each one on the display for a fixed dwell time.

Parameters:
DEPTH, 16, buffer entries; power of 2, minimum 2.
DWELL_CLKS, 25000000, cycles each byte is held during playback (1 s at 25 MHz); minimum 2.

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, asynchronous assert, active-low
i_RX_DV  in  1  single-cycle strobe: i_RX_Byte valid
i_RX_Byte  in  8  received UART byte
i_Play  in  1  single-cycle pulse (already debounced/edge-detected): start playback
i_Clear  in  1  single-cycle pulse: empty buffer, abort playback
o_Byte  out  8  byte to display (upper nibble = digit 1, lower nibble = digit 2)
o_Playing  out  1  high while in PLAY
o_Count  out  $clog2(DEPTH)+1  number of stored bytes
o_Full  out  1  o_Count == DEPTH
o_Overflow  out  1  sticky: a received byte was dropped

Behaviour:
- Interface: one clock, i_Clk. Reset i_Rst_L is asynchronous and active-low.
- Reset (asserted at any time, including mid-playback):
  - all outputs 0; state IDLE; count, read index and dwell counter 0.
  - Memory contents don't-care.
- All outputs are registered. Every response below appears on the cycle after the triggering input is sampled.
- Write path, accepted only in IDLE with o_Full=0:
  - i_RX_DV writes mem[count]; count+1; o_Byte <= i_RX_Byte.
- Dropped writes:
  - i_RX_DV when full, or while in PLAY: byte discarded, o_Overflow <= 1.
  - No other state changes.
- Priority, highest first: i_Clear > i_Play > i_RX_DV.
- Any simultaneous lower-priority event in the same cycle is discarded. A discarded i_RX_DV does not set o_Overflow when i_Clear won.
- i_Clear, any state:
  - count <= 0, o_Byte <= 0, o_Overflow <= 0, o_Playing <= 0.
  - state <= IDLE.
- State IDLE:
  - i_Play with count>0: state <= PLAY, idx <= 0, o_Byte <= mem[0], o_Playing <= 1, dwell counter <= 0.
  - i_Play with count==0: ignored.
- State PLAY:
  - Dwell counter increments each cycle.
  - When it reaches DWELL_CLKS-1: counter <= 0, idx+1, o_Byte <= mem[idx+1].
  - After the dwell of entry count-1 expires: state <= IDLE, o_Playing <= 0, o_Byte <= mem[count-1].
  - Each entry is therefore shown exactly DWELL_CLKS cycles.
- i_Play during PLAY restarts playback: idx <= 0, o_Byte <= mem[0], counter <= 0.
- Buffer contents and count are retained after playback. Playback is non-destructive and repeatable.
- o_Full is registered and consistent with o_Count on the same cycle.
- Index and count arithmetic: count saturates at DEPTH; idx never exceeds count-1. No wrap-around writes, because a full buffer drops input.

Optional Feature:
LOOP_PLAYBACK_EN
- Defined:
  - After the last entry's dwell, playback wraps to idx 0 (o_Byte <= mem[0]) and continues indefinitely.
  - i_Play during PLAY stops playback: state IDLE, o_Playing 0, o_Byte <= mem[count-1]. The play pulse acts as a toggle.
  - i_Clear still aborts.
- Undefined: single pass with restart-on-i_Play, as described in Behaviour.

Test Plan (DEPTH=4, DWELL_CLKS=4):
1. Reset released, no stimulus -> o_Byte=0x00, o_Count=0, o_Playing=0, o_Overflow=0. i_Play pulse -> stays IDLE, outputs unchanged.
2. RX 0x3A, 0xC5 -> o_Byte=0x3A then 0xC5, each one cycle after its strobe; o_Count=2.
3. Play pulse -> o_Playing=1; o_Byte=0x3A for 4 cycles, then 0xC5 for 4 cycles; then o_Playing=0, o_Byte=0xC5. During playback RX 0x77 -> dropped, o_Overflow=1, o_Count stays 2.
4. Write 0x01..0x04 -> o_Full=1, o_Count=4. RX 0x05 -> dropped, o_Overflow=1, o_Byte=0x04. i_Clear together with RX 0x06 -> o_Count=0, o_Byte=0x00, o_Overflow=0, o_Full=0.
5. During playback, at entry 1 cycle 2, assert i_Rst_L low -> all outputs 0 immediately (asynchronous). Release -> IDLE, o_Count=0.
6. LOOP_PLAYBACK_EN, 2 entries {0xAA, 0x55} -> sequence AA×4, 55×4, AA×4, ... Second i_Play -> o_Playing=0, o_Byte=0x55.
